// File: rtl/md_issue_ctrl.sv
// rtl/md_issue_ctrl.sv - EX-stage issue/completion controller for the multiply/divide unit
module md_issue_ctrl #(
   parameter int TIMEOUT_CYC = 64,
   parameter int CNT_W       = 7
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        Instr_valid,
   input  logic [5:0]  Instr_op,
   input  logic [5:0]  Instr_funct,
   input  logic [31:0] Rs_val,
   input  logic [31:0] Rt_val,
   input  logic        Flush,
   input  logic        Md_stall,
   input  logic [31:0] Res_out,
   output logic [3:0]  Md_op,
   output logic [31:0] Rs_out,
   output logic [31:0] Rt_out,
   output logic        Pipe_stall,
   output logic        Wb_valid,
   output logic [31:0] Wb_data,
   output logic        Timeout_err
);

   localparam logic [3:0] OP_NONE  = 4'b0000;
   localparam logic [3:0] OP_DIV   = 4'b0001;
   localparam logic [3:0] OP_DIVU  = 4'b0010;
   localparam logic [3:0] OP_MFHI  = 4'b0011;
   localparam logic [3:0] OP_MFLO  = 4'b0100;
   localparam logic [3:0] OP_MTHI  = 4'b0101;
   localparam logic [3:0] OP_MTLO  = 4'b0110;
   localparam logic [3:0] OP_MUL   = 4'b0111;
   localparam logic [3:0] OP_MULT  = 4'b1000;
   localparam logic [3:0] OP_MULTU = 4'b1001;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t           state, state_nxt;
   logic [3:0]       dec_op;
   logic [CNT_W-1:0] cnt;
   logic             accept, abort, stall_done, cnt_hit, complete, wb_op;

   always_comb begin
      dec_op = OP_NONE;
      if (Instr_op == 6'b000000) begin
         case (Instr_funct)
            6'b010000: dec_op = OP_MFHI;
            6'b010001: dec_op = OP_MTHI;
            6'b010010: dec_op = OP_MFLO;
            6'b010011: dec_op = OP_MTLO;
            6'b011000: dec_op = OP_MULT;
            6'b011001: dec_op = OP_MULTU;
            6'b011010: dec_op = OP_DIV;
            6'b011011: dec_op = OP_DIVU;
            default:   dec_op = OP_NONE;
         endcase
      end else if (Instr_op == 6'b011100 && Instr_funct == 6'b000010) begin
         dec_op = OP_MUL;
      end
   end

   assign accept     = (state == S_IDLE) & Instr_valid & (dec_op != OP_NONE) & ~Flush;
   assign abort      = Flush & ((state == S_ISSUE) | (state == S_WAIT));
   assign stall_done = (state == S_WAIT) & ~Md_stall;
   // The stall sample that would take the count to TIMEOUT_CYC forces completion.
   assign cnt_hit    = (state == S_WAIT) & Md_stall & (cnt == CNT_W'(TIMEOUT_CYC - 1));
   assign complete   = ~Flush & (stall_done | cnt_hit);
   assign wb_op      = (Md_op == OP_MFHI) | (Md_op == OP_MFLO) | (Md_op == OP_MUL);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = S_ISSUE;
         S_ISSUE: state_nxt = abort ? S_IDLE : S_WAIT;
         S_WAIT: begin
            if (abort)         state_nxt = S_IDLE;
            else if (complete) state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      Pipe_stall = accept | (state == S_ISSUE) | (state == S_WAIT);
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         Md_op       <= OP_NONE;
         Rs_out      <= '0;
         Rt_out      <= '0;
         Wb_valid    <= 1'b0;
         Wb_data     <= '0;
         Timeout_err <= 1'b0;
         cnt         <= '0;
      end else begin
         Wb_valid <= 1'b0;
         if (accept) begin
            Md_op  <= dec_op;
            Rs_out <= Rs_val;
            Rt_out <= Rt_val;
         end
         if (abort) begin
            Md_op <= OP_NONE;
            cnt   <= '0;
         end else if (state == S_WAIT) begin
            if (complete) begin
               Md_op    <= OP_NONE;
               cnt      <= '0;
               Wb_valid <= wb_op;
               Wb_data  <= stall_done ? Res_out : 32'd0;
               if (cnt_hit) Timeout_err <= 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else if (state == S_DONE) begin
            Md_op <= OP_NONE;
            cnt   <= '0;
         end
      end
   end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb/tb_md_issue_ctrl.sv - randomized self-checking bench for md_issue_ctrl
module tb_md_issue_ctrl;

   localparam int TMO = 64;

   logic        Clk = 1'b0;
   logic        Reset_n, Instr_valid, Flush, Md_stall;
   logic [5:0]  Instr_op, Instr_funct;
   logic [31:0] Rs_val, Rt_val, Res_out;
   logic [3:0]  Md_op;
   logic [31:0] Rs_out, Rt_out, Wb_data;
   logic        Pipe_stall, Wb_valid, Timeout_err;

   int          n_chk = 0;
   int          n_pass = 0;
   logic [31:0] m_wb_data;
   logic        m_tout;
   logic [11:0] instrs [0:11];

   md_issue_ctrl #(.TIMEOUT_CYC(TMO), .CNT_W(7)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Instr_valid(Instr_valid),
      .Instr_op(Instr_op), .Instr_funct(Instr_funct),
      .Rs_val(Rs_val), .Rt_val(Rt_val), .Flush(Flush),
      .Md_stall(Md_stall), .Res_out(Res_out), .Md_op(Md_op),
      .Rs_out(Rs_out), .Rt_out(Rt_out), .Pipe_stall(Pipe_stall),
      .Wb_valid(Wb_valid), .Wb_data(Wb_data), .Timeout_err(Timeout_err)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Instruction table: HI/LO-class encodings and what the unit sees / whether rd is written.
   function automatic void ref_dec(input logic [11:0] ins, output logic [3:0] code, output logic wb);
      code = 4'd0;
      wb   = 1'b0;
      case (ins)
         {6'b000000, 6'b010000}: begin code = 4'd3; wb = 1'b1; end
         {6'b000000, 6'b010001}: code = 4'd5;
         {6'b000000, 6'b010010}: begin code = 4'd4; wb = 1'b1; end
         {6'b000000, 6'b010011}: code = 4'd6;
         {6'b000000, 6'b011000}: code = 4'd8;
         {6'b000000, 6'b011001}: code = 4'd9;
         {6'b000000, 6'b011010}: code = 4'd1;
         {6'b000000, 6'b011011}: code = 4'd2;
         {6'b011100, 6'b000010}: begin code = 4'd7; wb = 1'b1; end
         default: ;
      endcase
   endfunction

   // One instruction from offer (cycle 0) until the controller is idle again; f<0 means no flush.
   task automatic do_txn(input logic [11:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] res, input int n, input int f);
      logic [3:0] code;
      logic       wb, acc, abrt, tmo;
      int         done, aend, last;
      ref_dec(ins, code, wb);
      acc  = (code != 4'd0) && (f != 0);
      tmo  = (n >= TMO);
      done = tmo ? 2 + TMO : 3 + n;
      abrt = acc && (f >= 1) && (f <= done - 1);
      aend = !acc ? -1 : (abrt ? f : done - 1);
      last = acc ? done + 1 : 3;
      for (int k = 0; k <= last; k++) begin
         @(negedge Clk);
         Instr_valid = (k == 0);
         {Instr_op, Instr_funct} = ins;
         if (acc && !abrt && k == done && $urandom_range(0, 1) == 1) begin
            Instr_valid = 1'b1;
            {Instr_op, Instr_funct} = {6'b000000, 6'b010010};
         end
         Rs_val   = (k == 0) ? rs : $urandom;
         Rt_val   = (k == 0) ? rt : $urandom;
         Flush    = (k == f);
         Md_stall = (k < 2 + n);
         Res_out  = (k == 2 + n) ? res : $urandom;
         #1;
         chk("pipe_stall", {31'd0, Pipe_stall}, {31'd0, acc && k <= aend});
         chk("wb_valid", {31'd0, Wb_valid}, {31'd0, acc && !abrt && wb && k == done});
         chk("md_op", {28'd0, Md_op}, (acc && k >= 1 && k <= aend) ? {28'd0, code} : 32'd0);
         if (acc && k >= 1 && k <= aend) begin
            chk("rs_out", Rs_out, rs);
            chk("rt_out", Rt_out, rt);
         end
      end
      if (acc && !abrt) begin
         m_wb_data = tmo ? 32'd0 : res;
         if (tmo) m_tout = 1'b1;
      end
      chk("wb_data", Wb_data, m_wb_data);
      chk("timeout_err", {31'd0, Timeout_err}, {31'd0, m_tout});
   endtask

   initial begin
      instrs[0]  = {6'b000000, 6'b010000};
      instrs[1]  = {6'b000000, 6'b010001};
      instrs[2]  = {6'b000000, 6'b010010};
      instrs[3]  = {6'b000000, 6'b010011};
      instrs[4]  = {6'b000000, 6'b011000};
      instrs[5]  = {6'b000000, 6'b011001};
      instrs[6]  = {6'b000000, 6'b011010};
      instrs[7]  = {6'b000000, 6'b011011};
      instrs[8]  = {6'b011100, 6'b000010};
      instrs[9]  = {6'b000000, 6'b100000};
      instrs[10] = {6'b011100, 6'b000000};
      instrs[11] = {6'b100011, 6'b010000};

      Reset_n = 1'b0; Instr_valid = 1'b0; Flush = 1'b0; Md_stall = 1'b0;
      Instr_op = '0; Instr_funct = '0; Rs_val = '0; Rt_val = '0; Res_out = '0;
      m_wb_data = '0; m_tout = 1'b0;
      #2;
      chk("rst_md_op", {28'd0, Md_op}, 32'd0);
      chk("rst_pipe_stall", {31'd0, Pipe_stall}, 32'd0);
      chk("rst_wb_valid", {31'd0, Wb_valid}, 32'd0);
      chk("rst_wb_data", Wb_data, 32'd0);
      chk("rst_timeout", {31'd0, Timeout_err}, 32'd0);
      chk("rst_rs_out", Rs_out, 32'd0);
      @(negedge Clk);
      Reset_n = 1'b1;

      do_txn({6'b000000, 6'b011000}, 32'd3, 32'hFFFF_FFFE, 32'h55, 0, -1);
      do_txn({6'b011100, 6'b000010}, 32'd7, 32'd6, 32'd42, 0, -1);
      do_txn({6'b000000, 6'b011010}, 32'd100, 32'd7, 32'd14, 32, -1);
      do_txn({6'b000000, 6'b011011}, 32'd9, 32'd0, 32'h77, 200, -1);
      do_txn({6'b000000, 6'b010010}, 32'd0, 32'd0, 32'hCAFE, 3, -1);
      do_txn({6'b000000, 6'b010000}, 32'd1, 32'd2, 32'hBEEF, 5, 7);
      do_txn({6'b000000, 6'b011010}, 32'd5, 32'd1, 32'h11, 70, 65);
      do_txn({6'b000000, 6'b011000}, 32'd4, 32'd4, 32'h22, 2, 0);
      do_txn({6'b011100, 6'b000010}, 32'd8, 32'd8, 32'd64, 1, 4);

      for (int t = 0; t < 40; t++) begin
         int n, f, sel, dn;
         sel = $urandom_range(0, 11);
         n   = ($urandom_range(0, 7) == 0) ? $urandom_range(60, 70) : $urandom_range(0, 10);
         dn  = (n >= TMO) ? 2 + TMO : 3 + n;
         sel = ($urandom_range(0, 3) == 0) ? sel : $urandom_range(0, 8);
         case ($urandom_range(0, 4))
            0:       f = 0;
            1, 2:    f = $urandom_range(1, dn);
            default: f = -1;
         endcase
         do_txn(instrs[sel], $urandom, $urandom, $urandom, n, f);
      end

      @(negedge Clk);
      Instr_valid = 1'b1; {Instr_op, Instr_funct} = {6'b000000, 6'b011001};
      Rs_val = 32'h1234; Rt_val = 32'h5678; Md_stall = 1'b1; Flush = 1'b0;
      @(negedge Clk);
      Instr_valid = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      #1;
      chk("pre_rst_stall", {31'd0, Pipe_stall}, 32'd1);
      #1;
      Reset_n = 1'b0;
      #1;
      chk("arst_md_op", {28'd0, Md_op}, 32'd0);
      chk("arst_rs_out", Rs_out, 32'd0);
      chk("arst_rt_out", Rt_out, 32'd0);
      chk("arst_pipe_stall", {31'd0, Pipe_stall}, 32'd0);
      chk("arst_wb_valid", {31'd0, Wb_valid}, 32'd0);
      chk("arst_wb_data", Wb_data, 32'd0);
      chk("arst_timeout", {31'd0, Timeout_err}, 32'd0);
      @(negedge Clk);
      Reset_n = 1'b1; Md_stall = 1'b0;
      m_wb_data = '0; m_tout = 1'b0;
      do_txn({6'b000000, 6'b100000}, 32'd1, 32'd2, 32'd3, 0, -1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
